// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
//   Valid/ready pipeline stage register with a two-entry skid buffer.
//   Main register M drives the outputs; skid register S catches the entry that
//   arrives in the cycle when in_ready_o is already committed high but the
//   downstream has stalled. in_ready_o comes straight from a flop, so no
//   combinational ready path runs between stages.
//
//   Optional feature macro: PIPE_DEBUG_INSTR_EN
//     Adds a 32-bit instruction tag (in_instr_i / out_instr_o) that travels
//     with each entry and reads 0 for bubbles.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   flush_i      synchronous kill of all held entries (highest priority)
//   in_valid_i   upstream entry present
//   in_ready_o   stage can accept (registered)
//   in_data_i    upstream datapath payload  [DATA_W]
//   in_ctrl_i    upstream control payload   [CTRL_W]
//   out_valid_o  entry presented downstream
//   out_ready_i  downstream accepts
//   out_data_o   presented datapath payload [DATA_W]
//   out_ctrl_o   presented control payload  [CTRL_W], zero on bubbles if CTRL_CLEAR
//   stall_cnt_o  saturating count of cycles with out_valid & !out_ready [CNT_W]
//   in_instr_i / out_instr_o  debug instruction sideband (PIPE_DEBUG_INSTR_EN)
// -----------------------------------------------------------------------------
module pipe_stage_skid #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CTRL_W     = 4,
  parameter int unsigned CTRL_CLEAR = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
`ifdef PIPE_DEBUG_INSTR_EN
  input  logic [31:0]       in_instr_i,
  output logic [31:0]       out_instr_o,
`endif
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e              state_q, state_d;
  logic                out_valid_q;
  logic                in_ready_q;
  logic [DATA_W-1:0]   m_data_q, s_data_q;
  logic [CTRL_W-1:0]   m_ctrl_q, s_ctrl_q;
  logic [CNT_W-1:0]    stall_cnt_q;

  logic                acc_s, drn_s;
  logic                load_m_in_s, load_m_skid_s, load_s_s;

  assign acc_s = in_valid_i & in_ready_q;
  assign drn_s = out_valid_q & out_ready_i;

  // State register; valid/ready are re-derived from the next state so both
  // leave the stage as flop outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_d != ST_EMPTY);
      in_ready_q  <= (state_d != ST_FULL);
    end
  end

  // Next-state logic; flush overrides every handshake.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc_s) state_d = ST_ONE;
          else       state_d = ST_EMPTY;
        end
        ST_ONE: begin
          if (acc_s && !drn_s)      state_d = ST_FULL;
          else if (!acc_s && drn_s) state_d = ST_EMPTY;
          else                      state_d = ST_ONE;
        end
        ST_FULL: begin
          if (drn_s) state_d = ST_ONE;
          else       state_d = ST_FULL;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Register load enables for M and S, decoded from the current state.
  always_comb begin
    load_m_in_s   = 1'b0;
    load_m_skid_s = 1'b0;
    load_s_s      = 1'b0;
    if (flush_i) begin
      load_m_in_s   = 1'b0;
      load_m_skid_s = 1'b0;
      load_s_s      = 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: load_m_in_s = acc_s;
        ST_ONE: begin
          load_m_in_s = acc_s & drn_s;
          load_s_s     = acc_s & ~drn_s;
        end
        ST_FULL:  load_m_skid_s = drn_s;
        default: begin
          load_m_in_s   = 1'b0;
          load_m_skid_s = 1'b0;
          load_s_s      = 1'b0;
        end
      endcase
    end
  end

  // Payload storage; flushed entries keep stale payload but lose validity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data_q <= '0;
      m_ctrl_q <= '0;
      s_data_q <= '0;
      s_ctrl_q <= '0;
    end else begin
      if (load_m_in_s) begin
        m_data_q <= in_data_i;
        m_ctrl_q <= in_ctrl_i;
      end else if (load_m_skid_s) begin
        m_data_q <= s_data_q;
        m_ctrl_q <= s_ctrl_q;
      end
      if (load_s_s) begin
        s_data_q <= in_data_i;
        s_ctrl_q <= in_ctrl_i;
      end
    end
  end

`ifdef PIPE_DEBUG_INSTR_EN
  logic [31:0] m_instr_q, s_instr_q;

  // Instruction tag follows exactly the same moves as the payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_instr_q <= 32'h0000_0000;
      s_instr_q <= 32'h0000_0000;
    end else begin
      if (load_m_in_s)        m_instr_q <= in_instr_i;
      else if (load_m_skid_s) m_instr_q <= s_instr_q;
      if (load_s_s)           s_instr_q <= in_instr_i;
    end
  end

  assign out_instr_o = m_instr_q & {32{out_valid_q}};
`else
  // Debug instruction sideband not built: no tag storage in this stage.
`endif

  // Saturating stall counter, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (out_valid_q && !out_ready_i && !flush_i && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Output drive; bubbles never present live control bits when CTRL_CLEAR.
  always_comb begin
    out_valid_o = out_valid_q;
    in_ready_o  = in_ready_q;
    out_data_o  = m_data_q;
    stall_cnt_o = stall_cnt_q;
    if (CTRL_CLEAR != 0) begin
      out_ctrl_o = m_ctrl_q & {CTRL_W{out_valid_q}};
    end else begin
      out_ctrl_o = m_ctrl_q;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_skid
//   Directed self-checking bench for pipe_stage_skid. A default-parameter
//   instance covers streaming, back-pressure, bubble gating, flush and async
//   reset; a CNT_W=4 instance covers counter saturation.
// -----------------------------------------------------------------------------
module tb_pipe_stage_skid;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [3:0]  in_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_ctrl;
  logic [15:0] stall_cnt;
`ifdef PIPE_DEBUG_INSTR_EN
  logic [31:0] in_instr;
  logic [31:0] out_instr;
`endif

  logic        in_valid2;
  logic        in_ready2;
  logic [7:0]  in_data2;
  logic [3:0]  in_ctrl2;
  logic        out_valid2;
  logic        out_ready2;
  logic [7:0]  out_data2;
  logic [3:0]  out_ctrl2;
  logic [3:0]  stall_cnt2;
`ifdef PIPE_DEBUG_INSTR_EN
  logic [31:0] out_instr2;
`endif

  int checks;
  int failures;

  pipe_stage_skid #(.DATA_W(32), .CTRL_W(4), .CTRL_CLEAR(1), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_ctrl_i   (in_ctrl),
`ifdef PIPE_DEBUG_INSTR_EN
    .in_instr_i  (in_instr),
    .out_instr_o (out_instr),
`endif
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_ctrl_o  (out_ctrl),
    .stall_cnt_o (stall_cnt)
  );

  pipe_stage_skid #(.DATA_W(8), .CTRL_W(4), .CTRL_CLEAR(1), .CNT_W(4)) dut_sat (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (1'b0),
    .in_valid_i  (in_valid2),
    .in_ready_o  (in_ready2),
    .in_data_i   (in_data2),
    .in_ctrl_i   (in_ctrl2),
`ifdef PIPE_DEBUG_INSTR_EN
    .in_instr_i  (32'h0000_0000),
    .out_instr_o (out_instr2),
`endif
    .out_valid_o (out_valid2),
    .out_ready_i (out_ready2),
    .out_data_o  (out_data2),
    .out_ctrl_o  (out_ctrl2),
    .stall_cnt_o (stall_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst        = 1'b1;
    flush      = 1'b0;
    in_valid   = 1'b0;
    in_data    = 32'h0;
    in_ctrl    = 4'h0;
    out_ready  = 1'b1;
    in_valid2  = 1'b0;
    in_data2   = 8'h0;
    in_ctrl2   = 4'h0;
    out_ready2 = 1'b1;
`ifdef PIPE_DEBUG_INSTR_EN
    in_instr   = 32'h0;
`endif
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (out_valid !== 1'b0)   begin failures++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1)    begin failures++; $display("FAIL reset_in_ready got=%0h exp=1", in_ready); end
    checks++; if (out_data !== 32'h0)   begin failures++; $display("FAIL reset_out_data got=%0h exp=0", out_data); end
    checks++; if (out_ctrl !== 4'h0)    begin failures++; $display("FAIL reset_out_ctrl got=%0h exp=0", out_ctrl); end
    checks++; if (stall_cnt !== 16'h0)  begin failures++; $display("FAIL reset_stall_cnt got=%0h exp=0", stall_cnt); end
  endtask

  task automatic test_stream();
    apply_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_ctrl   = 4'h5;
    for (int i = 0; i < 5; i++) begin
      in_data = 32'h10 + i;
      tick();
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stream_valid[%0d] got=%0h exp=1", i, out_valid); end
      checks++; if (out_data !== 32'h10 + i) begin failures++; $display("FAIL stream_data[%0d] got=%0h exp=%0h", i, out_data, 32'h10 + i); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready[%0d] got=%0h exp=1", i, in_ready); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0)  begin failures++; $display("FAIL stream_drained got=%0h exp=0", out_valid); end
    checks++; if (stall_cnt !== 16'h0) begin failures++; $display("FAIL stream_stall_cnt got=%0h exp=0", stall_cnt); end
  endtask

  task automatic test_back_pressure();
    apply_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    tick();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_one got=%0h exp=1", in_ready); end
    in_data = 32'hB;
    tick();
    in_valid = 1'b0;
    in_data  = 32'hDEAD;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_full got=%0h exp=0", in_ready); end
    tick();
    tick();
    checks++; if (in_ready !== 1'b0)   begin failures++; $display("FAIL bp_ready_held got=%0h exp=0", in_ready); end
    checks++; if (out_data !== 32'hA)  begin failures++; $display("FAIL bp_hold_a got=%0h exp=a", out_data); end
    checks++; if (stall_cnt !== 16'd3) begin failures++; $display("FAIL bp_stall_cnt got=%0d exp=3", stall_cnt); end
    out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'hA) begin failures++; $display("FAIL bp_release_a got=%0h/%0h exp=1/a", out_valid, out_data); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 32'hB) begin failures++; $display("FAIL bp_release_b got=%0h/%0h exp=1/b", out_valid, out_data); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_back got=%0h exp=1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0)  begin failures++; $display("FAIL bp_no_dup got=%0h exp=0", out_valid); end
    checks++; if (stall_cnt !== 16'd3) begin failures++; $display("FAIL bp_stall_final got=%0d exp=3", stall_cnt); end
  endtask

  task automatic test_bubble_gating();
    apply_reset();
    in_ctrl  = 4'b1111;
    in_data  = 32'h77;
    in_valid = 1'b0;
    tick();
    checks++; if (out_ctrl !== 4'b0000) begin failures++; $display("FAIL bubble_ctrl got=%0b exp=0000", out_ctrl); end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (out_ctrl !== 4'b1111) begin failures++; $display("FAIL bubble_live_ctrl got=%0b exp=1111", out_ctrl); end
    tick();
    checks++; if (out_valid !== 1'b0 || out_ctrl !== 4'b0000) begin failures++; $display("FAIL bubble_after got=%0h/%0b exp=0/0000", out_valid, out_ctrl); end
  endtask

  task automatic test_flush();
    apply_reset();
    out_ready = 1'b0;
    in_ctrl   = 4'b1010;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    tick();
    in_data = 32'hB;
    tick();
    in_data = 32'hC;
    flush   = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%0h exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL flush_ready got=%0h exp=1", in_ready); end
    checks++; if (out_ctrl !== 4'h0)  begin failures++; $display("FAIL flush_ctrl got=%0b exp=0000", out_ctrl); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_no_emit[%0d] got=%0h/%0h exp=0", i, out_valid, out_data); end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    out_ready = 1'b0;
    in_ctrl   = 4'b1111;
    in_valid  = 1'b1;
    in_data   = 32'h55;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    checks++; if (stall_cnt !== 16'd2) begin failures++; $display("FAIL async_pre_cnt got=%0d exp=2", stall_cnt); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0)  begin failures++; $display("FAIL async_valid got=%0h exp=0", out_valid); end
    checks++; if (out_ctrl !== 4'h0)   begin failures++; $display("FAIL async_ctrl got=%0b exp=0000", out_ctrl); end
    checks++; if (stall_cnt !== 16'h0) begin failures++; $display("FAIL async_cnt got=%0d exp=0", stall_cnt); end
    checks++; if (in_ready !== 1'b1)   begin failures++; $display("FAIL async_ready got=%0h exp=1", in_ready); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_saturation();
    apply_reset();
    out_ready2 = 1'b0;
    in_valid2  = 1'b1;
    in_data2   = 8'h3C;
    tick();
    in_valid2 = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    checks++; if (stall_cnt2 !== 4'd15) begin failures++; $display("FAIL sat_reach got=%0d exp=15", stall_cnt2); end
    for (int i = 0; i < 5; i++) tick();
    checks++; if (stall_cnt2 !== 4'd15) begin failures++; $display("FAIL sat_hold got=%0d exp=15", stall_cnt2); end
    checks++; if (out_valid2 !== 1'b1 || out_data2 !== 8'h3C) begin failures++; $display("FAIL sat_entry got=%0h/%0h exp=1/3c", out_valid2, out_data2); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_stream();
    test_back_pressure();
    test_bubble_gating();
    test_flush();
    test_async_reset();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
